l2_bank_tcdm_ctrl: RTL and testbench
====================================

Name: l2_bank_tcdm_ctrl

Overview:
TCDM slave-side controller between the JTAG lint master bus and one L2 SRAM macro bank. It accepts single-word TCDM requests (req/gnt, r_valid response) and drives a 1-cycle-latency synchronous SRAM. It handles address decode and range checking, and returns error responses for out-of-range accesses. After reset it runs a zero-initialisation sweep of the bank before granting any request.

Parameters:
BANK_SIZE, 64, bank depth in 32-bit words; power of two, ≥2.
BASE_ADDR, 32'h1C00_0000, byte base address of the bank; aligned to BANK_SIZE*4.
ERR_RDATA, 32'hBADA_CCE5, rdata returned on error responses.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
init_en_i  in  1  1: run zero sweep after reset; 0: skip straight to SERVE
tcdm_req_i  in  1  request valid
tcdm_add_i  in  32  byte address
tcdm_wen_i  in  1  1 = read, 0 = write (TCDM convention)
tcdm_be_i  in  4  byte enables
tcdm_wdata_i  in  32  write data
tcdm_gnt_o  out  1  request granted
tcdm_r_valid_o  out  1  response valid
tcdm_r_rdata_o  out  32  read data
tcdm_r_opc_o  out  1  1 = error response
mem_csn_o  out  1  SRAM chip select, active low
mem_wen_o  out  1  SRAM write enable, active low
mem_addr_o  out  $clog2(BANK_SIZE)  SRAM word address
mem_be_o  out  MW/8  SRAM byte enables (4; 4 when parity enabled, one per 9-bit lane)
mem_wdata_o  out  MW  SRAM write data (MW=32, or 36 with parity)
mem_rdata_i  in  MW  SRAM read data, valid one cycle after csn low with wen high
init_done_o  out  1  sweep complete
err_cnt_o  out  8  saturating error-response count

Behaviour:
- Reset values: gnt=0, r_valid=0, r_rdata=0, r_opc=0, mem_csn=1, mem_wen=1, mem_addr=0, mem_be=0, mem_wdata=0, init_done=0, err_cnt=0. The FSM enters INIT.
- FSM states: INIT, SERVE.
  - INIT: each cycle drives csn=0, wen=0, be=all ones, wdata=0, addr=sweep counter. The counter increments 0..BANK_SIZE-1, then the FSM moves to SERVE. The sweep takes exactly BANK_SIZE cycles. gnt=0 throughout. Requests held by the master stay pending, unchanged.
  - If init_en_i=0 when reset deasserts, the FSM goes directly to SERVE on the first clock.
  - init_done_o=1 exactly when in SERVE.
- SERVE: gnt_o is combinational: gnt = req. Every request is accepted the cycle it is presented; no backpressure.
- Decode: offset = add - BASE_ADDR.
  - In range when BASE_ADDR ≤ add < BASE_ADDR + BANK_SIZE*4.
  - Word index = offset[2+:log2(BANK_SIZE)]; add[1:0] is ignored.
- In-range granted request: same cycle, csn=0, wen=tcdm_wen, addr=index, be=tcdm_be, wdata=tcdm_wdata.
- Out-of-range granted request: csn stays 1, so the SRAM is untouched.
- Response: registered. r_valid=1 exactly one cycle after each grant, for reads and writes.
  - In-range read: rdata = mem_rdata_i.
  - Write: rdata = 0.
  - Out-of-range: r_opc=1, rdata=ERR_RDATA, err_cnt+1, saturating at 255.
  - Otherwise r_opc=0.
  - When r_valid=0, rdata and opc hold their last values.
- Back-to-back grants produce back-to-back responses, one per cycle, in order.
- Read after write to the same word on consecutive cycles returns the new data; the SRAM is write-first, and the controller adds no forwarding.
- Reset mid-sweep: the counter returns to 0 and the sweep restarts. Reset with a response pending drops the response (r_valid=0).

Optional Feature:
Macro L2_BANK_PARITY_EN.
- Defined: MW=36; each byte is stored as 9 bits, {even parity, byte}. Writes generate parity per enabled lane. INIT writes 9'h000 per lane.
- On an in-range read, any lane whose parity mismatches sets r_opc=1. rdata still carries the raw data bytes, and err_cnt increments.
- Not defined: MW=32, no parity logic, r_opc set only by out-of-range accesses.

Test Plan:
1. Reset with init_en_i=1, BANK_SIZE=64 → gnt=0 and csn=0/wen=0 for 64 cycles, addresses 0..63; init_done=1 on cycle 65. A read of BASE+0x04 then returns 0x00000000, r_opc=0.
2. Write 0xDEADBEEF to BASE+0x10 with be=4'b0011, then read BASE+0x10 → r_valid one cycle after each gnt; read rdata=0x0000BEEF.
3. Read BASE+BANK_SIZE*4 and BASE-4 → csn stays 1; responses r_opc=1, rdata=0xBADACCE5; err_cnt=2. 300 such requests → err_cnt=255.
4. Four back-to-back reads of words 0..3 preloaded with 0x11,0x22,0x33,0x44 → four consecutive r_valid cycles, data in order.
5. Assert rst_i at sweep cycle 20 → outputs return to reset values; a full 64-cycle sweep restarts from address 0. A req held during INIT is granted on the first SERVE cycle.
6. (L2_BANK_PARITY_EN) Force mem_rdata_i lane-1 parity bit flipped on a read of 0x12345678 → r_opc=1, rdata=0x12345678, err_cnt+1.

Source files
------------

// File: rtl/l2_bank_tcdm_ctrl.sv
// -----------------------------------------------------------------------------
// l2_bank_tcdm_ctrl
//
// TCDM slave-side controller that sits between the JTAG lint master bus and a
// single L2 SRAM bank with one cycle of read latency.
//
// After reset the bank is swept to zero, unless init_en_i is low. No request
// is granted during the sweep. After the sweep the controller serves
// single-word requests:
//   - Every request is granted in the cycle it is presented.
//   - An in-range request is passed straight through to the SRAM.
//   - An out-of-range request does not touch the SRAM. It gets an error
//     response (r_opc=1, rdata=ERR_RDATA) and bumps a saturating counter.
//   - The response comes exactly one cycle after the grant.
//
// Optional feature: define L2_BANK_PARITY_EN to store each byte as
// {even parity, byte} in a 36-bit SRAM word. A parity mismatch on any lane of
// an in-range read flags the response as an error. Without the macro the SRAM
// is 32 bits wide and has no parity logic.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   init_en_i        1: zero-sweep the bank after reset, 0: serve at once
//   tcdm_*           TCDM slave request (req/add/wen/be/wdata), grant and
//                    response (r_valid/r_rdata/r_opc)
//   mem_*            SRAM macro interface (active-low csn/wen, address,
//                    byte enables, write data, read data)
//   init_done_o      high while requests are being served
//   err_cnt_o        saturating count of error responses
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module l2_bank_tcdm_ctrl #(
  parameter int unsigned BANK_SIZE = 64,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
  parameter logic [31:0] ERR_RDATA = 32'hBADA_CCE5,
  localparam int unsigned AW = $clog2(BANK_SIZE),
`ifdef L2_BANK_PARITY_EN
  localparam int unsigned MW = 36
`else
  localparam int unsigned MW = 32
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_en_i,
  input  logic            tcdm_req_i,
  input  logic [31:0]     tcdm_add_i,
  input  logic            tcdm_wen_i,
  input  logic [3:0]      tcdm_be_i,
  input  logic [31:0]     tcdm_wdata_i,
  output logic            tcdm_gnt_o,
  output logic            tcdm_r_valid_o,
  output logic [31:0]     tcdm_r_rdata_o,
  output logic            tcdm_r_opc_o,
  output logic            mem_csn_o,
  output logic            mem_wen_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [MW/8-1:0] mem_be_o,
  output logic [MW-1:0]   mem_wdata_o,
  input  logic [MW-1:0]   mem_rdata_i,
  output logic            init_done_o,
  output logic [7:0]      err_cnt_o
);

  localparam logic [31:0] BANK_BYTES = 32'(BANK_SIZE) << 2;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // SRAM word encode/decode helpers
  // ---------------------------------------------------------------------------
`ifdef L2_BANK_PARITY_EN
  // Each byte lane becomes 9 bits, {even parity, byte}.
  function automatic logic [MW-1:0] encode_word(input logic [31:0] data);
    logic [MW-1:0] word;
    word = {MW{1'b0}};
    for (int lane = 0; lane < 4; lane++) begin
      word[9*lane +: 9] = {^data[8*lane +: 8], data[8*lane +: 8]};
    end
    return word;
  endfunction

  // Strips the parity bits and returns the raw data bytes.
  function automatic logic [31:0] decode_word(input logic [MW-1:0] word);
    logic [31:0] data;
    data = 32'h0000_0000;
    for (int lane = 0; lane < 4; lane++) begin
      data[8*lane +: 8] = word[9*lane +: 8];
    end
    return data;
  endfunction

  // With even parity, a good lane XORs to zero over all 9 bits.
  function automatic logic parity_error(input logic [MW-1:0] word);
    logic err;
    err = 1'b0;
    for (int lane = 0; lane < 4; lane++) begin
      err = err | (^word[9*lane +: 9]);
    end
    return err;
  endfunction
`else
  function automatic logic [MW-1:0] encode_word(input logic [31:0] data);
    return data;
  endfunction

  function automatic logic [31:0] decode_word(input logic [MW-1:0] word);
    return word;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e        state_r;
  logic [AW-1:0] sweep_cnt_r;
  logic          init_done_r;

  logic          r_valid_r;
  logic          rd_pend_r;      // the response in flight is an in-range read
  logic          opc_hold_r;
  logic [31:0]   rdata_hold_r;
  logic [7:0]    err_cnt_r;

  logic [31:0]   offset_s;
  logic          in_range_s;
  logic [AW-1:0] index_s;
  logic          gnt_s;
  logic          oor_s;
  logic          rd_s;
  logic          rd_resp_s;
  logic          par_err_s;
  logic [1:0]    err_inc_s;
  logic [8:0]    err_sum_s;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // A single unsigned compare covers both bounds, because an address below
  // BASE_ADDR wraps to a huge offset.
  assign offset_s   = tcdm_add_i - BASE_ADDR;
  assign in_range_s = (offset_s < BANK_BYTES);
  assign index_s    = offset_s[2 +: AW];

  assign gnt_s      = (state_r == SERVE) && tcdm_req_i;
  assign oor_s      = gnt_s && !in_range_s;
  assign rd_s       = gnt_s && in_range_s && tcdm_wen_i;
  assign rd_resp_s  = r_valid_r && rd_pend_r;

`ifdef L2_BANK_PARITY_EN
  assign par_err_s  = rd_resp_s && parity_error(mem_rdata_i);
`else
  assign par_err_s  = 1'b0;
`endif

  assign err_inc_s  = {1'b0, oor_s} + {1'b0, par_err_s};
  assign err_sum_s  = {1'b0, err_cnt_r} + {7'd0, err_inc_s};

  // ---------------------------------------------------------------------------
  // Sequencing and response
  // ---------------------------------------------------------------------------

  // Init/serve FSM: zero sweep counter and the registered init_done flag.
  // When init_en_i is low in INIT, the FSM leaves for SERVE on the next clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= INIT;
      sweep_cnt_r <= {AW{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if (!init_en_i || (sweep_cnt_r == AW'(BANK_SIZE - 1))) begin
            state_r     <= SERVE;
            sweep_cnt_r <= {AW{1'b0}};
            init_done_r <= 1'b1;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + AW'(1);
          end
        end
        SERVE: begin
          state_r     <= SERVE;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= INIT;
          sweep_cnt_r <= {AW{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // SRAM drive. During the sweep the SRAM gets zero writes. When serving, an
  // in-range request goes straight through. Everything is held idle while
  // reset is asserted.
  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_addr_o  = {AW{1'b0}};
    mem_be_o    = {(MW/8){1'b0}};
    mem_wdata_o = {MW{1'b0}};
    if (rst_i) begin
      mem_csn_o = 1'b1;
    end else if (state_r == INIT) begin
      if (init_en_i) begin
        mem_csn_o   = 1'b0;
        mem_wen_o   = 1'b0;
        mem_addr_o  = sweep_cnt_r;
        mem_be_o    = {(MW/8){1'b1}};
        mem_wdata_o = {MW{1'b0}};
      end else begin
        mem_csn_o = 1'b1;
      end
    end else if (tcdm_req_i && in_range_s) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = tcdm_wen_i;
      mem_addr_o  = index_s;
      mem_be_o    = tcdm_be_i;
      mem_wdata_o = encode_word(tcdm_wdata_i);
    end else begin
      mem_csn_o = 1'b1;
    end
  end

  // Response pipeline.
  // - Writes and errors set their rdata/opc at grant time.
  // - In-range read data appears straight from the SRAM in the response
  //   cycle. It is captured afterwards so that rdata holds its value while
  //   r_valid is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_r    <= 1'b0;
      rd_pend_r    <= 1'b0;
      opc_hold_r   <= 1'b0;
      rdata_hold_r <= 32'h0000_0000;
      err_cnt_r    <= 8'd0;
    end else begin
      r_valid_r <= gnt_s;
      rd_pend_r <= rd_s;
      if (gnt_s && !rd_s) begin
        rdata_hold_r <= oor_s ? ERR_RDATA : 32'h0000_0000;
        opc_hold_r   <= oor_s;
      end else if (gnt_s) begin
        opc_hold_r   <= 1'b0;
      end else if (rd_resp_s) begin
        rdata_hold_r <= decode_word(mem_rdata_i);
        opc_hold_r   <= par_err_s;
      end else begin
        opc_hold_r   <= opc_hold_r;
      end
      err_cnt_r <= err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tcdm_gnt_o     = gnt_s;
  assign tcdm_r_valid_o = r_valid_r;
  assign tcdm_r_rdata_o = rd_resp_s ? decode_word(mem_rdata_i) : rdata_hold_r;
`ifdef L2_BANK_PARITY_EN
  assign tcdm_r_opc_o   = rd_resp_s ? par_err_s : opc_hold_r;
`else
  assign tcdm_r_opc_o   = opc_hold_r;
`endif
  assign init_done_o    = init_done_r;
  assign err_cnt_o      = err_cnt_r;

endmodule

// File: tb/tb_l2_bank_tcdm_ctrl.sv
`timescale 1ns/1ps

module tb_l2_bank_tcdm_ctrl;

  localparam int          BANK = 64;
  localparam int          AW   = 6;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam logic [31:0] ERRD = 32'hBADA_CCE5;
`ifdef L2_BANK_PARITY_EN
  localparam int          MW   = 36;
`else
  localparam int          MW   = 32;
`endif
  localparam int          LW   = MW / 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init_en = 1'b1;
  logic            req = 1'b0;
  logic [31:0]     add = 32'h0;
  logic            wen = 1'b1;
  logic [3:0]      be = 4'h0;
  logic [31:0]     wdata = 32'h0;
  logic            gnt;
  logic            r_valid;
  logic [31:0]     r_rdata;
  logic            r_opc;
  logic            mem_csn;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [MW/8-1:0] mem_be;
  logic [MW-1:0]   mem_wdata;
  logic [MW-1:0]   mem_rdata;
  logic            init_done;
  logic [7:0]      err_cnt;

  l2_bank_tcdm_ctrl #(
    .BANK_SIZE (BANK),
    .BASE_ADDR (BASE),
    .ERR_RDATA (ERRD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .init_en_i      (init_en),
    .tcdm_req_i     (req),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_wdata_i   (wdata),
    .tcdm_gnt_o     (gnt),
    .tcdm_r_valid_o (r_valid),
    .tcdm_r_rdata_o (r_rdata),
    .tcdm_r_opc_o   (r_opc),
    .mem_csn_o      (mem_csn),
    .mem_wen_o      (mem_wen),
    .mem_addr_o     (mem_addr),
    .mem_be_o       (mem_be),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .init_done_o    (init_done),
    .err_cnt_o      (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro stub: 1-cycle read latency, per-lane byte writes.
  logic [MW-1:0] sram [BANK];
  logic [MW-1:0] sram_q = '0;
  logic [MW-1:0] flip_mask = '0;
  always @(posedge clk) begin
    if (!mem_csn) begin
      if (!mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][b*LW +: LW] <= mem_wdata[b*LW +: LW];
      end else begin
        sram_q <= sram[mem_addr];
      end
    end
  end
  assign mem_rdata = sram_q ^ flip_mask;

  // Reference model and scoreboard.
  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    int          due;
  } resp_t;

  logic [31:0] ref_mem [BANK];
  resp_t       exp_q[$];
  int          exp_err = 0;
  logic        perr_next = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] tb_data(input logic [MW-1:0] raw);
    logic [31:0] d;
    for (int b = 0; b < 4; b++) d[8*b +: 8] = raw[LW*b +: 8];
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every negedge, r_valid must match the scoreboard head's due cycle.
  resp_t mon_e;
  logic  mon_expv;
  always @(negedge clk) begin
    mon_expv = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    check1("r_valid", r_valid, mon_expv);
    if (mon_expv) begin
      mon_e = exp_q.pop_front();
      if (r_valid) begin
        check("r_rdata", r_rdata, mon_e.rdata);
        check1("r_opc", r_opc, mon_e.opc);
      end
    end
  end

  // Called at posedge+1; presents one request for one cycle and returns at
  // the following posedge+1.
  task automatic issue(input logic [31:0] a, input logic rd, input logic [3:0] b,
                       input logic [31:0] wd);
    longint la;
    logic   inr;
    int     idx;
    resp_t  r;
    la  = longint'(a);
    inr = (la >= longint'(BASE)) && (la < longint'(BASE) + BANK * 4);
    idx = inr ? int'((la - longint'(BASE)) / 4) : 0;
    r.due = cyc + 1;
    if (!inr) begin
      r.rdata = ERRD;
      r.opc   = 1'b1;
      if (exp_err < 255) exp_err++;
    end else if (rd) begin
      r.rdata = ref_mem[idx];
      r.opc   = perr_next;
    end else begin
      for (int k = 0; k < 4; k++)
        if (b[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
      r.rdata = 32'h0;
      r.opc   = 1'b0;
    end
    exp_q.push_back(r);
    req = 1'b1; add = a; wen = rd; be = b; wdata = wd;
    @(negedge clk);
    check1("gnt", gnt, 1'b1);
    if (inr) begin
      check1("csn_in", mem_csn, 1'b0);
      check1("mem_wen", mem_wen, rd);
      check("mem_addr", 32'(mem_addr), 32'(idx));
      check("mem_be", 32'(mem_be), 32'(b));
      if (!rd) check("mem_wdata", tcdm_data_of_mem(), wd);
    end else begin
      check1("csn_oor", mem_csn, 1'b1);
    end
    @(posedge clk); #1;
    req = 1'b0;
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    if (perr_next && inr && rd && exp_err < 255) exp_err++;
  endtask

  function automatic logic [31:0] tcdm_data_of_mem();
    return tb_data(mem_wdata);
  endfunction

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check1("rst_gnt", gnt, 1'b0);
    check1("rst_r_valid", r_valid, 1'b0);
    check("rst_r_rdata", r_rdata, 32'h0);
    check1("rst_r_opc", r_opc, 1'b0);
    check1("rst_csn", mem_csn, 1'b1);
    check1("rst_wen", mem_wen, 1'b1);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_be", 32'(mem_be), 32'h0);
    check("rst_wdata", tb_data(mem_wdata), 32'h0);
    check1("rst_init_done", init_done, 1'b0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
  endtask

  // Checks n sweep cycles; starts right after reset release (posedge+1).
  task automatic sweep_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check1("init_csn", mem_csn, 1'b0);
      check1("init_wen", mem_wen, 1'b0);
      check("init_addr", 32'(mem_addr), 32'(i));
      check("init_be", 32'(mem_be), 32'hF);
      check("init_wdata", 32'(mem_wdata), 32'h0);
      check1("init_gnt", gnt, 1'b0);
      check1("init_done_low", init_done, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < BANK; i++) begin
      sram[i] = MW'({$urandom, $urandom});
      ref_mem[i] = 32'h0;
    end

    // 1: reset, full sweep with a read held pending, then it is granted.
    req = 1'b1; add = BASE + 32'h4; wen = 1'b1; be = 4'hF;
    repeat (2) @(posedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_cycles(BANK);
    check1("init_done_serve", init_done, 1'b1);
    issue(BASE + 32'h4, 1'b1, 4'hF, 32'h0);
    idle(1);

    // 2: partial write then read back.
    issue(BASE + 32'h10, 1'b0, 4'b0011, 32'hDEAD_BEEF);
    idle(1);
    issue(BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    idle(1);

    // 3: both range boundaries give errors.
    issue(BASE + 32'(BANK * 4), 1'b1, 4'hF, 32'h0);
    issue(BASE - 32'h4, 1'b1, 4'hF, 32'h0);
    idle(1);
    check("err_cnt_two", 32'(err_cnt), 32'd2);
    issue(BASE + 32'(BANK * 4) - 32'h1, 1'b1, 4'hF, 32'h0);

    // 4: preload words 0..3, back-to-back reads, then read-after-write.
    for (int i = 0; i < 4; i++) issue(BASE + 32'(4 * i), 1'b0, 4'hF, 32'h11 * 32'(i + 1));
    for (int i = 0; i < 4; i++) issue(BASE + 32'(4 * i), 1'b1, 4'hF, 32'h0);
    issue(BASE + 32'h20, 1'b0, 4'hF, 32'hA5A5_0F0F);
    issue(BASE + 32'h22, 1'b1, 4'hF, 32'h0);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: a = BASE - 32'(4 * $urandom_range(1, 8));
        1: a = BASE + 32'(BANK * 4) + 32'(4 * $urandom_range(0, 8));
        2: a = $urandom;
        default: a = BASE + 32'(4 * $urandom_range(0, BANK - 1)) + 32'($urandom_range(0, 3));
      endcase
      issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

`ifdef L2_BANK_PARITY_EN
    // 6: flipped lane-1 parity bit on a read.
    issue(BASE + 32'h14, 1'b0, 4'hF, 32'h1234_5678);
    idle(1);
    flip_mask = 36'h1 << 17;
    perr_next = 1'b1;
    issue(BASE + 32'h14, 1'b1, 4'hF, 32'h0);
    perr_next = 1'b0;
    idle(1);
    flip_mask = '0;
    check("err_cnt_parity", 32'(err_cnt), 32'(exp_err));
`endif

    // 3b: many errors saturate the counter.
    for (int i = 0; i < 300; i++) issue(BASE - 32'h4, 1'b1, 4'hF, 32'h0);
    idle(1);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // init_en=0: no sweep, SERVE after one clock, SRAM contents preserved.
    issue(BASE, 1'b0, 4'hF, 32'hCAFE_F00D);
    idle(2);
    init_en = 1'b0;
    rst = 1'b1;
    exp_err = 0;
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("noinit_csn", mem_csn, 1'b1);
    check1("noinit_done0", init_done, 1'b0);
    @(posedge clk); #1;
    check1("noinit_done1", init_done, 1'b1);
    issue(BASE, 1'b1, 4'hF, 32'h0);
    idle(1);
    init_en = 1'b1;

    // 5: response pending when reset hits is dropped; mid-sweep reset restarts.
    req = 1'b1; add = BASE + 32'h8; wen = 1'b1; be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    req = 1'b0;
    for (int i = 0; i < BANK; i++) ref_mem[i] = 32'h0;
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b1; add = BASE + 32'h30; wen = 1'b1; be = 4'hF;
    sweep_cycles(20);
    rst = 1'b1;
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_cycles(BANK);
    check1("init_done_again", init_done, 1'b1);
    issue(BASE + 32'h30, 1'b1, 4'hF, 32'h0);
    issue(BASE, 1'b1, 4'hF, 32'h0);
    issue(BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
